// File: rtl/ili9341_spi_receiver_if.sv
// Bus bundle for the ILI9341 SPI receiver: SPI pins in, decoded command/pixel stream out.
// proto_err is only present when ILI_RX_PROTO_ERR_EN is defined.
interface ili9341_spi_receiver_if #(
  parameter int CW = 9
);
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_cs;
  logic          spi_dc;
  logic          cmd_valid;
  logic [7:0]    cmd_byte;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          frame_done;
`ifdef ILI_RX_PROTO_ERR_EN
  logic          proto_err;

  modport master (
    output spi_sck, spi_mosi, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, frame_done, proto_err
  );
  modport slave (
    input  spi_sck, spi_mosi, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, frame_done, proto_err
  );
`else
  modport master (
    output spi_sck, spi_mosi, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, frame_done
  );
  modport slave (
    input  spi_sck, spi_mosi, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, pix_valid, pix_data, pix_x, pix_y, frame_done
  );
`endif
endinterface

// File: rtl/ili9341_spi_receiver.sv
// ILI9341 4-wire SPI receive model: oversampled byte assembly plus CASET/PASET/RAMWR decode
// into an RGB565 pixel stream. Optional sticky proto_err under ILI_RX_PROTO_ERR_EN.
//
// state  | meaning
// IDLE   | no command in progress, data bytes ignored
// CA0-3  | collecting CASET parameters SC hi/lo, EC hi/lo
// PA0-3  | collecting PASET parameters SP hi/lo, EP hi/lo
// RW_HI  | RAMWR, waiting for pixel high byte
// RW_LO  | RAMWR, waiting for pixel low byte
module ili9341_spi_receiver #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240,
  parameter int CW     = 9
) (
  input logic                   clk_out,
  input logic                   rst,
  ili9341_spi_receiver_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CA0, S_CA1, S_CA2, S_CA3, S_PA0, S_PA1, S_PA2, S_PA3, S_RW_HI, S_RW_LO
  } state_t;

  logic [1:0]    r_sck_sy, r_mosi_sy, r_cs_sy, r_dc_sy;
  logic          r_sck_prev;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic          r_dc_first;
  logic          r_byte_stb;
  logic [7:0]    r_byte;
  logic          r_byte_dc;
  logic          w_rise;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_sc, r_ec, r_sp, r_ep, r_x, r_y;
  logic [CW-1:0] w_sc_nxt, w_ec_nxt, w_sp_nxt, w_ep_nxt, w_x_nxt, w_y_nxt;
  logic [15:0]   r_par_s, w_par_s_nxt;
  logic [7:0]    r_par_e_hi, w_par_e_hi_nxt;
  logic [7:0]    r_hi, w_hi_nxt;
  logic          r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0]    r_cmd_byte, w_cmd_byte_nxt;
  logic          r_pix_valid, w_pix_valid_nxt;
  logic [15:0]   r_pix_data, w_pix_data_nxt;
  logic [CW-1:0] r_pix_x, r_pix_y, w_pix_x_nxt, w_pix_y_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic [2*CW-1:0] w_win;

`ifdef ILI_RX_PROTO_ERR_EN
  logic          r_cs_abort;
  logic          r_proto_err, w_proto_err_nxt;
`endif

  // Clamp end to the panel, then start to end; returns {start, end} truncated to CW bits.
  function automatic logic [2*CW-1:0] f_commit(input logic [15:0] s, input logic [15:0] e,
                                               input logic [15:0] lim);
    logic [15:0] e_c;
    logic [15:0] s_c;
    e_c = (e > lim) ? lim : e;
    s_c = (s > e_c) ? e_c : s;
    return {CW'(s_c), CW'(e_c)};
  endfunction

  assign w_rise = r_sck_sy[1] & ~r_sck_prev & ~r_cs_sy[1];

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      r_sck_sy   <= '0;
      r_mosi_sy  <= '0;
      r_cs_sy    <= 2'b11;
      r_dc_sy    <= '0;
      r_sck_prev <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_dc_first <= 1'b0;
      r_byte_stb <= 1'b0;
      r_byte     <= '0;
      r_byte_dc  <= 1'b0;
`ifdef ILI_RX_PROTO_ERR_EN
      r_cs_abort <= 1'b0;
`endif
    end else begin
      r_sck_sy   <= {r_sck_sy[0], bus.spi_sck};
      r_mosi_sy  <= {r_mosi_sy[0], bus.spi_mosi};
      r_cs_sy    <= {r_cs_sy[0], bus.spi_cs};
      r_dc_sy    <= {r_dc_sy[0], bus.spi_dc};
      r_sck_prev <= r_sck_sy[1];
      r_byte_stb <= 1'b0;
`ifdef ILI_RX_PROTO_ERR_EN
      r_cs_abort <= r_cs_sy[1] && (r_bit_cnt != 3'd0);
`endif
      if (r_cs_sy[1]) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_shift   <= {r_shift[5:0], r_mosi_sy[1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd0) r_dc_first <= r_dc_sy[1];
        if (r_bit_cnt == 3'd7) begin
          r_byte_stb <= 1'b1;
          r_byte     <= {r_shift, r_mosi_sy[1]};
          r_byte_dc  <= r_dc_first;
        end
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sc         <= '0;
      r_ec         <= CW'(WIDTH - 1);
      r_sp         <= '0;
      r_ep         <= CW'(HEIGHT - 1);
      r_x          <= '0;
      r_y          <= '0;
      r_par_s      <= '0;
      r_par_e_hi   <= '0;
      r_hi         <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_byte   <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_frame_done <= 1'b0;
`ifdef ILI_RX_PROTO_ERR_EN
      r_proto_err  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sc         <= w_sc_nxt;
      r_ec         <= w_ec_nxt;
      r_sp         <= w_sp_nxt;
      r_ep         <= w_ep_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_par_s      <= w_par_s_nxt;
      r_par_e_hi   <= w_par_e_hi_nxt;
      r_hi         <= w_hi_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_byte   <= w_cmd_byte_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_pix_data   <= w_pix_data_nxt;
      r_pix_x      <= w_pix_x_nxt;
      r_pix_y      <= w_pix_y_nxt;
      r_frame_done <= w_frame_done_nxt;
`ifdef ILI_RX_PROTO_ERR_EN
      r_proto_err  <= w_proto_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sc_nxt         = r_sc;
    w_ec_nxt         = r_ec;
    w_sp_nxt         = r_sp;
    w_ep_nxt         = r_ep;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_par_s_nxt      = r_par_s;
    w_par_e_hi_nxt   = r_par_e_hi;
    w_hi_nxt         = r_hi;
    w_cmd_valid_nxt  = 1'b0;
    w_cmd_byte_nxt   = r_cmd_byte;
    w_pix_valid_nxt  = 1'b0;
    w_pix_data_nxt   = r_pix_data;
    w_pix_x_nxt      = r_pix_x;
    w_pix_y_nxt      = r_pix_y;
    w_frame_done_nxt = 1'b0;
    w_win            = '0;
`ifdef ILI_RX_PROTO_ERR_EN
    w_proto_err_nxt  = r_proto_err | r_cs_abort;
`endif
    if (r_byte_stb) begin
      if (!r_byte_dc) begin
        w_cmd_valid_nxt = 1'b1;
        w_cmd_byte_nxt  = r_byte;
`ifdef ILI_RX_PROTO_ERR_EN
        if (r_state inside {S_CA0, S_CA1, S_CA2, S_CA3, S_PA0, S_PA1, S_PA2, S_PA3, S_RW_LO})
          w_proto_err_nxt = 1'b1;
`endif
        case (r_byte)
          8'h2A:   w_state_nxt = S_CA0;
          8'h2B:   w_state_nxt = S_PA0;
          8'h2C: begin
            w_state_nxt = S_RW_HI;
            w_x_nxt     = r_sc;
            w_y_nxt     = r_sp;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_CA0, S_PA0: begin
            w_par_s_nxt[15:8] = r_byte;
            w_state_nxt       = (r_state == S_CA0) ? S_CA1 : S_PA1;
          end
          S_CA1, S_PA1: begin
            w_par_s_nxt[7:0] = r_byte;
            w_state_nxt      = (r_state == S_CA1) ? S_CA2 : S_PA2;
          end
          S_CA2, S_PA2: begin
            w_par_e_hi_nxt = r_byte;
            w_state_nxt    = (r_state == S_CA2) ? S_CA3 : S_PA3;
          end
          S_CA3: begin
            w_win       = f_commit(r_par_s, {r_par_e_hi, r_byte}, 16'(WIDTH - 1));
            w_sc_nxt    = w_win[2*CW-1:CW];
            w_ec_nxt    = w_win[CW-1:0];
            w_state_nxt = S_IDLE;
          end
          S_PA3: begin
            w_win       = f_commit(r_par_s, {r_par_e_hi, r_byte}, 16'(HEIGHT - 1));
            w_sp_nxt    = w_win[2*CW-1:CW];
            w_ep_nxt    = w_win[CW-1:0];
            w_state_nxt = S_IDLE;
          end
          S_RW_HI: begin
            w_hi_nxt    = r_byte;
            w_state_nxt = S_RW_LO;
          end
          S_RW_LO: begin
            w_pix_valid_nxt = 1'b1;
            w_pix_data_nxt  = {r_hi, r_byte};
            w_pix_x_nxt     = r_x;
            w_pix_y_nxt     = r_y;
            w_state_nxt     = S_RW_HI;
            if (r_x == r_ec) begin
              w_x_nxt = r_sc;
              if (r_y == r_ep) begin
                w_y_nxt          = r_sp;
                w_frame_done_nxt = 1'b1;
              end else begin
                w_y_nxt = r_y + 1'b1;
              end
            end else begin
              w_x_nxt = r_x + 1'b1;
            end
          end
          default: begin
`ifdef ILI_RX_PROTO_ERR_EN
            w_proto_err_nxt = 1'b1;
`endif
          end
        endcase
      end
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_byte   = r_cmd_byte;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_data   = r_pix_data;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.frame_done = r_frame_done;
`ifdef ILI_RX_PROTO_ERR_EN
  assign bus.proto_err  = r_proto_err;
`endif

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// Randomized directed bench for ili9341_spi_receiver against a queue-based panel model.
module tb_ili9341_spi_receiver;
  localparam int CW = 9;

  logic clk_out = 1'b0;
  logic rst     = 1'b0;
  always #5 clk_out = ~clk_out;

  ili9341_spi_receiver_if #(.CW(CW)) bus ();

  ili9341_spi_receiver #(.WIDTH(240), .HEIGHT(240), .CW(CW)) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic          fd;
    logic [CW-1:0] y;
    logic [CW-1:0] x;
    logic [15:0]   d;
  } pix_t;

  int n_cmp = 0;
  int n_bad = 0;
  int stray_fd = 0;

  pix_t       act_pix[$];
  pix_t       exp_pix[$];
  logic [7:0] act_cmd[$];
  logic [7:0] exp_cmd[$];

  // panel model
  int m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  int m_mode;            // 0 none, 1 column window, 2 row window, 3 memory write
  int m_np;
  int m_par[4];
  bit m_have_hi;
  int m_hi;
  bit m_perr;

  always @(negedge clk_out) begin
    if (rst) begin
      if (bus.pix_valid)
        act_pix.push_back({bus.frame_done, bus.pix_y, bus.pix_x, bus.pix_data});
      else if (bus.frame_done)
        stray_fd++;
      if (bus.cmd_valid) act_cmd.push_back(bus.cmd_byte);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 239; m_x = 0; m_y = 0;
    m_mode = 0; m_np = 0; m_have_hi = 0; m_hi = 0; m_perr = 0;
    act_pix.delete(); exp_pix.delete(); act_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    pix_t e;
    int s, en;
    if (!dc) begin
      exp_cmd.push_back(8'(b));
      if (m_mode == 1 || m_mode == 2) m_perr = 1;
      if (m_mode == 3 && m_have_hi) m_perr = 1;
      m_have_hi = 0;
      m_np = 0;
      if (b == 'h2A) m_mode = 1;
      else if (b == 'h2B) m_mode = 2;
      else if (b == 'h2C) begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
      else m_mode = 0;
    end else if (m_mode == 0) begin
      m_perr = 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_np] = b;
      m_np++;
      if (m_np == 4) begin
        s  = m_par[0] * 256 + m_par[1];
        en = m_par[2] * 256 + m_par[3];
        if (en > 239) en = 239;
        if (s > en) s = en;
        if (m_mode == 1) begin m_sc = s; m_ec = en; end
        else begin m_sp = s; m_ep = en; end
        m_mode = 0;
        m_np = 0;
      end
    end else if (!m_have_hi) begin
      m_hi = b;
      m_have_hi = 1;
    end else begin
      e.fd = (m_x == m_ec && m_y == m_ep);
      e.x  = m_x[CW-1:0];
      e.y  = m_y[CW-1:0];
      e.d  = 16'(m_hi * 256 + b);
      exp_pix.push_back(e);
      m_have_hi = 0;
      if (m_x == m_ec) begin
        m_x = m_sc;
        m_y = (m_y == m_ep) ? m_sp : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
    bus.spi_cs = 1'b0;
    bus.spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      repeat (2) @(negedge clk_out);
      bus.spi_sck = 1'b1;
      repeat (2) @(negedge clk_out);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    send_bits(dc, b, 8);
    model_byte(dc, int'(b));
    if ($urandom_range(0, 7) == 0) begin
      repeat (2) @(negedge clk_out);
      bus.spi_cs = 1'b1;
      repeat (3) @(negedge clk_out);
    end
  endtask

  task automatic set_win(input bit col, input int s, input int e);
    send_byte(1'b0, col ? 8'h2A : 8'h2B);
    send_byte(1'b1, 8'(s >> 8));
    send_byte(1'b1, 8'(s));
    send_byte(1'b1, 8'(e >> 8));
    send_byte(1'b1, 8'(e));
  endtask

  task automatic send_pixels(input int n, input logic [15:0] fixed, input bit rnd);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = rnd ? 16'($urandom) : fixed;
      send_byte(1'b1, p[15:8]);
      send_byte(1'b1, p[7:0]);
    end
  endtask

  task automatic check_all(input string tag);
    pix_t a, e;
    logic [7:0] ca, ce;
    repeat (8) @(negedge clk_out);
    chk({tag, "_pix_count"}, 64'(act_pix.size()), 64'(exp_pix.size()));
    while (act_pix.size() > 0 && exp_pix.size() > 0) begin
      a = act_pix.pop_front();
      e = exp_pix.pop_front();
      chk({tag, "_pix"}, 64'(a), 64'(e));
    end
    chk({tag, "_cmd_count"}, 64'(act_cmd.size()), 64'(exp_cmd.size()));
    while (act_cmd.size() > 0 && exp_cmd.size() > 0) begin
      ca = act_cmd.pop_front();
      ce = exp_cmd.pop_front();
      chk({tag, "_cmd"}, 64'(ca), 64'(ce));
    end
    act_pix.delete(); exp_pix.delete(); act_cmd.delete(); exp_cmd.delete();
`ifdef ILI_RX_PROTO_ERR_EN
    chk({tag, "_proto_err"}, 64'(bus.proto_err), 64'(m_perr));
`endif
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'(0));
    chk({tag, "_cmd_byte"}, 64'(bus.cmd_byte), 64'(0));
    chk({tag, "_pix_valid"}, 64'(bus.pix_valid), 64'(0));
    chk({tag, "_pix_data"}, 64'(bus.pix_data), 64'(0));
    chk({tag, "_pix_x"}, 64'(bus.pix_x), 64'(0));
    chk({tag, "_pix_y"}, 64'(bus.pix_y), 64'(0));
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'(0));
`ifdef ILI_RX_PROTO_ERR_EN
    chk({tag, "_proto_err"}, 64'(bus.proto_err), 64'(0));
`endif
  endtask

  initial begin
    int s, e, npix;
    bus.spi_sck = 1'b0; bus.spi_cs = 1'b1; bus.spi_mosi = 1'b0; bus.spi_dc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_out);
    chk_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk_out);

    // 2x2 window, one full frame
    set_win(1'b1, 0, 1);
    set_win(1'b0, 0, 1);
    send_byte(1'b0, 8'h2C);
    send_pixels(4, 16'h0, 1'b1);
    check_all("win2x2");

    // random windows, including clamp and start>end cases, with wrap and dangling bytes
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(0, 239);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : s + $urandom_range(0, 3);
      set_win(1'b1, s, e);
      s = $urandom_range(0, 239);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : s + $urandom_range(0, 2);
      set_win(1'b0, s, e);
      if ($urandom_range(0, 3) == 0) send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, 8'h2C);
      npix = $urandom_range(4, 24);
      send_pixels(npix, 16'h0, 1'b1);
      if ($urandom_range(0, 2) == 0) send_byte(1'b1, 8'($urandom));
      check_all("random");
    end

    // cs raised mid-byte drops the partial byte
    send_bits(1'b0, 8'hFF, 5);
    m_perr = 1;
    repeat (2) @(negedge clk_out);
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk_out);
    send_byte(1'b0, 8'h2A);
    check_all("cs_abort");
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hEF);
    set_win(1'b0, 0, 239);
    check_all("restore");

    // high byte then command: no pixel, later data ignored
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hF8);
    send_byte(1'b0, 8'h00);
    send_byte(1'b1, 8'h55);
    check_all("drop_hi");

    // end column 300 clamps to 239; 240 pixels then one more lands on row 1
    set_win(1'b1, 0, 300);
    send_byte(1'b0, 8'h2C);
    send_pixels(241, 16'h07FF, 1'b0);
    check_all("clamp");

    // reset in the middle of a memory write
    send_byte(1'b0, 8'h2C);
    send_pixels(2, 16'h0, 1'b1);
    send_byte(1'b1, 8'hA5);
    check_all("pre_reset");
    send_bits(1'b1, 8'hC3, 3);
    rst = 1'b0;
    bus.spi_sck = 1'b0;
    bus.spi_cs = 1'b1;
    @(negedge clk_out);
    chk_outputs_zero("midrst");
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_out);
    send_byte(1'b0, 8'h2C);
    send_pixels(3, 16'h0, 1'b1);
    check_all("post_reset");

    chk("stray_frame_done", 64'(stray_fd), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
